// File: rtl/sram_arbiter.sv
// Two-port round-robin arbiter in front of a single-port SRAM, with an optional
// bounded ownership lock for back-to-back bursts from one requester.
module sram_arbiter #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MAX_LOCK = 16
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              m0_req_i,
  input  logic              m0_we_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [3:0]        m0_sel_i,
  input  logic [DATA_W-1:0] m0_data_i,
  input  logic              m0_lock_i,
  output logic              m0_ack_o,
  output logic [DATA_W-1:0] m0_data_o,

  input  logic              m1_req_i,
  input  logic              m1_we_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [3:0]        m1_sel_i,
  input  logic [DATA_W-1:0] m1_data_i,
  input  logic              m1_lock_i,
  output logic              m1_ack_o,
  output logic [DATA_W-1:0] m1_data_o,

  output logic              sram_ce_o,
  output logic              sram_we_o,
  output logic [ADDR_W-1:0] sram_addr_o,
  output logic [3:0]        sram_sel_o,
  output logic [DATA_W-1:0] sram_data_o,
  input  logic [DATA_W-1:0] sram_data_i,

  output logic              busy_o
);

  localparam int unsigned CntW = $clog2(MAX_LOCK + 1);
  typedef logic [CntW-1:0] cnt_t;
  localparam cnt_t CntMax = cnt_t'(MAX_LOCK);

  typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

  logic [1:0]        req, we, lock;
  logic [ADDR_W-1:0] addr  [2];
  logic [3:0]        sel   [2];
  logic [DATA_W-1:0] wdata [2];

  assign req      = {m1_req_i, m0_req_i};
  assign we       = {m1_we_i, m0_we_i};
  assign lock     = {m1_lock_i, m0_lock_i};
  assign addr[0]  = m0_addr_i;
  assign addr[1]  = m1_addr_i;
  assign sel[0]   = m0_sel_i;
  assign sel[1]   = m1_sel_i;
  assign wdata[0] = m0_data_i;
  assign wdata[1] = m1_data_i;

  state_e            state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_grant_q, last_grant_d;
  logic              lock_on_q, lock_on_d;
  logic              lock_owner_q, lock_owner_d;
  cnt_t              lock_cnt_q, lock_cnt_d;
  logic              op_we_q, op_we_d;
  logic [1:0]        ack_q, ack_d;
  logic              ce_q, ce_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        sel_q, sel_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic held, grant, winner;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    lock_on_d    = lock_on_q;
    lock_owner_d = lock_owner_q;
    lock_cnt_d   = lock_cnt_q;
    op_we_d      = op_we_q;
    ack_d        = '0;
    ce_d         = 1'b0;
    we_d         = 1'b0;
    addr_d       = addr_q;
    sel_d        = sel_q;
    wdata_d      = wdata_q;
    held         = 1'b0;
    grant        = 1'b0;
    winner       = 1'b0;

    unique case (state_q)
      StIdle: begin
        // A lock survives only while its owner keeps asking and the burst bound is not hit.
        held = lock_on_q && lock[lock_owner_q] && req[lock_owner_q] && (lock_cnt_q != CntMax);
        if (held) begin
          grant  = 1'b1;
          winner = lock_owner_q;
        end else if (&req) begin
          grant  = 1'b1;
          winner = ~last_grant_q;
        end else if (req[0]) begin
          grant  = 1'b1;
          winner = 1'b0;
        end else if (req[1]) begin
          grant  = 1'b1;
          winner = 1'b1;
        end
        lock_on_d = held;
        if (grant) begin
          state_d      = StIssue;
          owner_d      = winner;
          last_grant_d = winner;
          op_we_d      = we[winner];
          ce_d         = 1'b1;
          we_d         = we[winner];
          addr_d       = addr[winner];
          sel_d        = sel[winner];
          wdata_d      = wdata[winner];
          // Count only grants that make the other port wait.
          if (!req[~winner]) lock_cnt_d = '0;
          else if (held)     lock_cnt_d = lock_cnt_q + cnt_t'(1);
          else               lock_cnt_d = cnt_t'(1);
        end else begin
          lock_cnt_d = '0;
        end
      end
      StIssue: begin
        state_d        = StResp;
        ack_d[owner_q] = 1'b1;
      end
      StResp: begin
        state_d = StIdle;
        if (lock[owner_q]) begin
          lock_on_d    = 1'b1;
          lock_owner_d = owner_q;
        end else begin
          lock_on_d  = 1'b0;
          lock_cnt_d = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      lock_on_q    <= 1'b0;
      lock_owner_q <= 1'b0;
      lock_cnt_q   <= '0;
      op_we_q      <= 1'b0;
      ack_q        <= '0;
      ce_q         <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      sel_q        <= '0;
      wdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      lock_on_q    <= lock_on_d;
      lock_owner_q <= lock_owner_d;
      lock_cnt_q   <= lock_cnt_d;
      op_we_q      <= op_we_d;
      ack_q        <= ack_d;
      ce_q         <= ce_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      sel_q        <= sel_d;
      wdata_q      <= wdata_d;
    end
  end

  assign sram_ce_o   = ce_q;
  assign sram_we_o   = we_q;
  assign sram_addr_o = addr_q;
  assign sram_sel_o  = sel_q;
  assign sram_data_o = wdata_q;
  assign busy_o      = (state_q != StIdle);
  assign m0_ack_o    = ack_q[0];
  assign m1_ack_o    = ack_q[1];

  // Read data comes straight from the SRAM during the response cycle.
  assign m0_data_o = (state_q == StResp && owner_q == 1'b0 && !op_we_q) ? sram_data_i : '0;
  assign m1_data_o = (state_q == StResp && owner_q == 1'b1 && !op_we_q) ? sram_data_i : '0;

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Shares the single-port `sram` between two requesters: port 0 is the packet loader/host writer, port 1 is the `executor`.
- Replaces the direct executor-to-SRAM connection. The SRAM-side ports connect 1:1 to `sram` (ce, we, addr_i, sel_i, data_i, data_o).
- Arbitration is round-robin with an optional bounded lock, so one requester can run back-to-back accesses (e.g. a checksum pass).

Parameters:
- ADDR_W, 32, address width (matches `ADDR_BUS).
- DATA_W, 32, data width (matches `DATA_BUS).
- MAX_LOCK, 16, maximum consecutive grants to a locking owner while the other port is requesting.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-low reset.
- mN_req_i  in  1  access request, N=0,1. Held high with fields stable until mN_ack_o.
- mN_we_i  in  1  1 = write, 0 = read.
- mN_addr_i  in  ADDR_W  word address.
- mN_sel_i  in  4  byte enables for writes.
- mN_data_i  in  DATA_W  write data.
- mN_lock_i  in  1  request to keep ownership for the next access.
- mN_ack_o  out  1  one-cycle completion strobe.
- mN_data_o  out  DATA_W  read data, valid when mN_ack_o=1 and the access was a read. 0 otherwise.
- sram_ce_o  out  1  SRAM chip enable.
- sram_we_o  out  1  SRAM write enable.
- sram_addr_o  out  ADDR_W  SRAM address.
- sram_sel_o  out  4  SRAM byte select.
- sram_data_o  out  DATA_W  SRAM write data.
- sram_data_i  in  DATA_W  SRAM read data, valid the cycle after the SRAM samples ce.
- busy_o  out  1  high in any state other than IDLE.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; all sram_* outputs 0; all acks 0; all mN_data_o 0; busy_o=0.
  - last_grant=1, so port 0 wins the first contest.
  - lock_owner cleared; lock_cnt=0.
  - An in-flight access is abandoned and never acked.
- FSM states: IDLE -> ISSUE -> RESP -> IDLE. All outputs are registered except mN_data_o (see RESP).
- IDLE, choosing the winner:
  - If a lock is active: only lock_owner may be granted; the other port waits.
  - Otherwise: a sole requester wins. With both requesting, the winner is the port != last_grant.
  - On a grant: register the winner's we/addr/sel/data into sram_*_o, set sram_ce_o=1, set last_grant=winner, go to ISSUE.
  - No request: stay in IDLE with sram_ce_o=0.
- ISSUE (1 cycle): SRAM samples the access. Next state RESP; sram_ce_o and sram_we_o return to 0.
- RESP (1 cycle):
  - owner_ack_o=1.
  - owner_data_o = sram_data_i for reads, 0 for writes.
  - The non-owner port sees ack=0 and data 0.
  - Next state IDLE.
- Latency: request seen in IDLE at cycle T -> sram_ce_o=1 in T+1 -> ack in T+2. Single-port throughput is one access per 3 cycles.
- Master rule: deassert req or present a new request the cycle after ack. The arbiter does not sample req in RESP.
- Lock handling:
  - Sampled in RESP. If owner_lock_i=1, lock_owner=owner.
  - lock_cnt increments on each locked grant while the other port's req is high. It clears when the other port is idle or the lock drops.
  - In IDLE, the lock is released if lock_owner's lock_i=0, or lock_owner's req=0, or lock_cnt==MAX_LOCK.
  - On a forced release the other port wins the next grant.
- Stable-field violation (master changes fields before ack): the values latched in IDLE are used; no error reporting.
- Widths pass through; no arithmetic on data.

Test Plan:
- Single read: SRAM word 16 preloaded 0x45000054; m1 read addr 16 at cycle T -> sram_ce_o=1, sram_addr_o=16, sram_we_o=0 in T+1; m1_ack_o=1 with m1_data_o=0x45000054 in T+2; m0_ack_o stays 0.
- Contention after reset: m0 and m1 both request reads in the first cycle -> m0 acked at T+2, m1 acked at T+5. A repeat contest then grants m0 first, since last_grant=1 after m1's access.
- Byte-enable write: word 6 = 0xAABBCCDD; m0 writes addr 6, sel 4'b1100, data 0x00001111 -> m0 acked, no read data (m0_data_o=0). A following m1 read of addr 6 returns 0x0000CCDD.
- Lock bound: m1 holds lock_i=1 and requests continuously while m0 requests -> m1 gets exactly 16 consecutive grants, then m0 is granted, then arbitration resumes round-robin.
- Reset mid-access: rst driven low during ISSUE -> sram_ce_o=0 and busy_o=0 immediately; no ack ever issued. After release, the first request from m1 completes normally with 2-cycle latency.
